pacman_motion: RTL and testbench
================================

// Module: pacman_motion
// PURPOSE
//   Per-frame Pac-Man movement engine feeding color_mapper's pacmanX/pacmanY/last_keypress.
//   Once per frame it latches a keyboard direction request and probes the wall map
//   (check_wall-style combinational lookup) at the candidate sprite's leading corners.
//   It then turns, continues or stops; a blocked turn stays buffered for later frames.
// PARAMETERS
//   START_X  10'd312  reset/top-left X of 8x8 sprite
//   START_Y  10'd232  reset/top-left Y of 8x8 sprite
//   STEP     10'd1    pixels moved per accepted frame
//   X_MAX    10'd632  largest legal top-left X (640-8); min legal X is 0
//   Y_MAX    10'd472  largest legal top-left Y (480-8); min legal Y is 0
//   KEY_W/A/S/D  8'h1A/8'h04/8'h16/8'h07  USB keycodes for up/left/down/right
// PORTS
//   Clk            in   1   system clock
//   Reset          in   1   asynchronous, active-high reset
//   frame_clk      in   1   vsync-rate pulse; rising edge (Clk-sampled) = frame tick
//   keycode        in   8   current USB keycode, 0 = none
//   isDefeated     in   1   freeze movement while high
//   probe_wall     in   1   wall flag for (probe_x,probe_y), combinational same cycle
//   probe_x        out  10  pixel X being probed
//   probe_y        out  10  pixel Y being probed
//   pacmanX        out  10  sprite top-left X
//   pacmanY        out  10  sprite top-left Y
//   last_keypress  out  2   facing dir: 0 right, 1 down, 2 left, 3 up
//   moving         out  1   1 = moved on most recent evaluated frame
//   busy           out  1   FSM not in IDLE
// BEHAVIOUR
// - Reset (async, any state): pacmanX=START_X, pacmanY=START_Y, last_keypress=0, moving=0,
//   busy=0, probe_x/probe_y=0, cur_valid=0, req_valid=0, frame_clk_d=0, state=IDLE.
// - tick = frame_clk & ~frame_clk_d (frame_clk_d registered). Acted on only in IDLE with isDefeated=0.
//   Ticks in other states are dropped.
// - On tick: W/A/S/D keycode -> req_dir and req_valid=1; other keycodes leave req unchanged.
// - Candidate for dir d: (nx,ny) = (pacmanX,pacmanY) +/- STEP on d's axis.
//   Leading corners: right (nx+7,ny),(nx+7,ny+7); left (nx,ny),(nx,ny+7);
//   down (nx,ny+7),(nx+7,ny+7); up (nx,ny),(nx+7,ny).
// - Out of bounds = blocked without wall lookup: nx<0, nx>X_MAX, ny<0, ny>Y_MAX.
//   Use 11-bit signed compare; no wrap-around.
// - FSM: IDLE, RQ0, RQ1, CU0, CU1, MOVE. Probe outputs are driven combinationally from state.
//   Each probe state samples probe_wall at its clock edge.
//   IDLE -tick-> RQ0 if req_valid else CU0.
//   RQ0: probe req corner0.  RQ1: probe req corner1.
//     If both clear and in bounds: dir=req_dir, req_valid=0, -> MOVE.
//     Else -> CU0 if cur_valid, else IDLE with moving=0.
//   CU0/CU1: probe cur_dir corners. Clear -> MOVE; blocked -> IDLE, moving=0, cur_valid=0.
//   MOVE: commit pos+=STEP*dir, cur_dir=dir, cur_valid=1, last_keypress=dir, moving=1; -> IDLE.
// - Latency: tick in IDLE at cycle t, turn accepted -> new pacmanX/Y visible at t+4.
//   Straight/fallback move -> t+4 (no req) or t+6 (blocked req).
// - Req equal to cur_dir is accepted normally, which clears req_valid.
//   The reverse direction is always probed like any turn.
// - isDefeated high in any non-IDLE state: abort to IDLE; position, dir and req unchanged.
// - busy=1 in every state except IDLE. pacmanX/Y change only in MOVE.
// TESTING
// 1 Reset mid-RQ1 -> next cycle pacmanX=312, pacmanY=232, last_keypress=0, busy=0, moving=0.
// 2 Open field; keycode=8'h07, tick -> pacmanX=313 at t+4, last_keypress=0, moving=1.
//   Then keycode=0 and 3 ticks -> pacmanX=316.
// 3 Moving right; key W with wall above, tick -> RQ probes then CU probes; pacmanX+1, last_keypress=0.
//   Clear wall and tick -> pacmanY-1, last_keypress=3.
// 4 pacmanX=632 moving right, no req, tick -> no probe_wall dependence, pacmanX stays 632, moving=0.
// 5 isDefeated=1 during CU0 -> IDLE next cycle, position and dir unchanged.
//   Ticks ignored while high.
// 6 Second frame_clk rising edge while busy -> ignored; exactly one STEP per evaluated frame.

Source files
------------

// File: rtl/pacman_motion.sv
// rtl/pacman_motion.sv - per-frame Pac-Man movement engine with wall probing and buffered turns
module pacman_motion #(
  parameter logic [9:0] START_X = 10'd312,
  parameter logic [9:0] START_Y = 10'd232,
  parameter logic [9:0] STEP    = 10'd1,
  parameter logic [9:0] X_MAX   = 10'd632,
  parameter logic [9:0] Y_MAX   = 10'd472,
  parameter logic [7:0] KEY_W   = 8'h1A,
  parameter logic [7:0] KEY_A   = 8'h04,
  parameter logic [7:0] KEY_S   = 8'h16,
  parameter logic [7:0] KEY_D   = 8'h07
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       isDefeated,
  input  logic       probe_wall,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  output logic [9:0] pacmanX,
  output logic [9:0] pacmanY,
  output logic [1:0] last_keypress,
  output logic       moving,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, RQ0, RQ1, CU0, CU1, MOVE} state_t;

  localparam logic signed [10:0] STEP_S  = $signed({1'b0, STEP});
  localparam logic signed [10:0] X_MAX_S = $signed({1'b0, X_MAX});
  localparam logic signed [10:0] Y_MAX_S = $signed({1'b0, Y_MAX});

  state_t state, state_n;
  logic frame_clk_d, tick;
  logic key_hit;
  logic [1:0] key_dir;
  logic [1:0] req_dir, cur_dir, dir, pdir;
  logic req_valid, cur_valid, mv_req, blk0;
  logic probing, corner1, oob, probe_blk;
  logic signed [10:0] nx, ny;
  logic [9:0] px, py;

  assign tick      = frame_clk & ~frame_clk_d;
  assign busy      = (state != IDLE);
  assign probe_blk = oob | probe_wall;

  // Keycode decode; direction codes: 0 right, 1 down, 2 left, 3 up
  always_comb begin
    key_hit = 1'b1;
    key_dir = 2'd0;
    if (keycode == KEY_D)      key_dir = 2'd0;
    else if (keycode == KEY_S) key_dir = 2'd1;
    else if (keycode == KEY_A) key_dir = 2'd2;
    else if (keycode == KEY_W) key_dir = 2'd3;
    else                       key_hit = 1'b0;
  end

  // Which direction/corner is being evaluated, derived purely from the state
  always_comb begin
    pdir    = dir;
    probing = 1'b0;
    corner1 = 1'b0;
    case (state)
      RQ0: begin pdir = req_dir; probing = 1'b1; end
      RQ1: begin pdir = req_dir; probing = 1'b1; corner1 = 1'b1; end
      CU0: begin pdir = cur_dir; probing = 1'b1; end
      CU1: begin pdir = cur_dir; probing = 1'b1; corner1 = 1'b1; end
      default: pdir = dir;
    endcase
  end

  // Candidate position one step along pdir, bounds test and leading-corner probe address
  always_comb begin
    nx = $signed({1'b0, pacmanX});
    ny = $signed({1'b0, pacmanY});
    case (pdir)
      2'd0:    nx = $signed({1'b0, pacmanX}) + STEP_S;
      2'd1:    ny = $signed({1'b0, pacmanY}) + STEP_S;
      2'd2:    nx = $signed({1'b0, pacmanX}) - STEP_S;
      default: ny = $signed({1'b0, pacmanY}) - STEP_S;
    endcase
    oob = (nx < 11'sd0) || (nx > X_MAX_S) || (ny < 11'sd0) || (ny > Y_MAX_S);
    px  = nx[9:0];
    py  = ny[9:0];
    case (pdir)
      2'd0: begin px = nx[9:0] + 10'd7; py = ny[9:0] + (corner1 ? 10'd7 : 10'd0); end
      2'd1: begin px = nx[9:0] + (corner1 ? 10'd7 : 10'd0); py = ny[9:0] + 10'd7; end
      2'd2: py = ny[9:0] + (corner1 ? 10'd7 : 10'd0);
      default: px = nx[9:0] + (corner1 ? 10'd7 : 10'd0);
    endcase
    probe_x = probing ? px : 10'd0;
    probe_y = probing ? py : 10'd0;
  end

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; a frame with neither a request nor a current direction stays idle
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (tick && !isDefeated) begin
              if (key_hit || req_valid) state_n = RQ0;
              else if (cur_valid)       state_n = CU0;
            end
      RQ0:  state_n = RQ1;
      RQ1:  if (!blk0 && !probe_blk) state_n = MOVE;
            else if (cur_valid)      state_n = CU0;
            else                     state_n = IDLE;
      CU0:  state_n = CU1;
      CU1:  state_n = (blk0 || probe_blk) ? IDLE : MOVE;
      MOVE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && isDefeated) state_n = IDLE;
  end

  // Datapath: request buffer, probe results, direction bookkeeping and position commit
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_clk_d   <= 1'b0;
      pacmanX       <= START_X;
      pacmanY       <= START_Y;
      last_keypress <= 2'd0;
      moving        <= 1'b0;
      req_valid     <= 1'b0;
      req_dir       <= 2'd0;
      cur_valid     <= 1'b0;
      cur_dir       <= 2'd0;
      dir           <= 2'd0;
      mv_req        <= 1'b0;
      blk0          <= 1'b0;
    end else begin
      frame_clk_d <= frame_clk;
      if (!(state != IDLE && isDefeated)) begin
        case (state)
          IDLE: if (tick && !isDefeated) begin
                  if (key_hit) begin
                    req_dir   <= key_dir;
                    req_valid <= 1'b1;
                  end else if (!req_valid && !cur_valid) begin
                    moving <= 1'b0;
                  end
                end
          RQ0, CU0: blk0 <= probe_blk;
          RQ1: if (!blk0 && !probe_blk) begin
                 dir    <= req_dir;
                 mv_req <= 1'b1;
               end else if (!cur_valid) begin
                 moving <= 1'b0;
               end
          CU1: if (blk0 || probe_blk) begin
                 moving    <= 1'b0;
                 cur_valid <= 1'b0;
               end else begin
                 dir    <= cur_dir;
                 mv_req <= 1'b0;
               end
          MOVE: begin
                  pacmanX       <= nx[9:0];
                  pacmanY       <= ny[9:0];
                  cur_dir       <= dir;
                  cur_valid     <= 1'b1;
                  last_keypress <= dir;
                  moving        <= 1'b1;
                  if (mv_req) req_valid <= 1'b0;
                end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pacman_motion.sv
// tb/tb_pacman_motion.sv - scoreboard bench for pacman_motion
module tb_pacman_motion;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       isDefeated = 1'b0;
  logic       probe_wall;
  logic [9:0] probe_x, probe_y, pacmanX, pacmanY;
  logic [1:0] last_keypress;
  logic       moving, busy;

  typedef struct {int x; int y; int lk; int mv;} exp_t;
  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wall_y = 0;
  logic busy_q = 1'b0;

  pacman_motion dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .isDefeated(isDefeated), .probe_wall(probe_wall), .probe_x(probe_x),
    .probe_y(probe_y), .pacmanX(pacmanX), .pacmanY(pacmanY),
    .last_keypress(last_keypress), .moving(moving), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Wall map: every pixel row above wall_y is solid
  assign probe_wall = (int'(probe_y) < wall_y);

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int lk, input int mv);
    exp_t t;
    t.x = x; t.y = y; t.lk = lk; t.mv = mv;
    sb.push_back(t);
  endtask

  task automatic frame(input int x, input int y, input int lk, input int mv);
    push(x, y, lk, mv);
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    repeat (10) @(negedge Clk);
  endtask

  task automatic frame_lat(input string name, input int ox, input int oy,
                           input int x, input int y, input int lk, input int mv, input int lat);
    push(x, y, lk, mv);
    @(negedge Clk) frame_clk = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      @(negedge Clk);
      if (i == 1) frame_clk = 1'b0;
      if (i == lat - 1) chk({name, "_before"}, (pacmanX == ox[9:0] && pacmanY == oy[9:0]) ? 1 : 0, 1);
      if (i == lat)     chk({name, "_at"}, (pacmanX == x[9:0] && pacmanY == y[9:0]) ? 1 : 0, 1);
    end
    repeat (8) @(negedge Clk);
  endtask

  task automatic chk_home(input string name);
    chk({name, "_x"}, pacmanX, 312);
    chk({name, "_y"}, pacmanY, 232);
    chk({name, "_lk"}, last_keypress, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_moving"}, moving, 0);
  endtask

  // Monitor: each end of an evaluation (busy falling) is compared with the oldest expectation
  always @(negedge Clk) begin
    if (Reset) begin
      busy_q = 1'b0;
    end else begin
      if (busy_q && !busy) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_frame: got x=%0d y=%0d lk=%0d mv=%0d expected no frame",
                   pacmanX, pacmanY, last_keypress, moving);
        end else begin
          e = sb.pop_front();
          if (pacmanX != e.x[9:0] || pacmanY != e.y[9:0] ||
              last_keypress != e.lk[1:0] || moving != e.mv[0]) begin
            n_bad++;
            $display("FAIL frame: got x=%0d y=%0d lk=%0d mv=%0d expected x=%0d y=%0d lk=%0d mv=%0d",
                     pacmanX, pacmanY, last_keypress, moving, e.x, e.y, e.lk, e.mv);
          end
        end
      end
      busy_q = busy;
    end
  end

  initial begin
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk_home("reset");

    // Reset while in RQ1
    keycode = 8'h07;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    @(negedge Clk);
    chk("rq1_busy", busy, 1);
    Reset = 1'b1;
    @(negedge Clk);
    chk_home("reset_rq1");
    Reset = 1'b0;
    repeat (3) @(negedge Clk);

    // Open field: turn right, then keep going
    frame_lat("turn_right", 312, 232, 313, 232, 0, 1, 4);
    keycode = 8'h00;
    frame(314, 232, 0, 1);
    frame(315, 232, 0, 1);
    frame(316, 232, 0, 1);
    chk("straight_x", pacmanX, 316);

    // Blocked up-turn falls back to right, then is taken once the wall is gone
    wall_y  = 232;
    keycode = 8'h1A;
    frame_lat("blocked_turn", 316, 232, 317, 232, 0, 1, 6);
    wall_y  = 0;
    keycode = 8'h00;
    frame_lat("buffered_up", 317, 232, 317, 231, 3, 1, 4);

    // Run right to the edge; the step past X_MAX is refused without any wall
    keycode = 8'h07;
    frame(318, 231, 0, 1);
    keycode = 8'h00;
    for (int x = 319; x <= 632; x++) frame(x, 231, 0, 1);
    frame(632, 231, 0, 0);
    chk("edge_x", pacmanX, 632);

    // Defeat during CU0 aborts with nothing changed; ticks ignored while defeated
    keycode = 8'h04;
    frame(631, 231, 2, 1);
    keycode = 8'h00;
    push(631, 231, 2, 1);
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    chk("cu0_busy", busy, 1);
    isDefeated = 1'b1;
    @(negedge Clk);
    chk("abort_busy", busy, 0);
    chk("abort_x", pacmanX, 631);
    chk("abort_lk", last_keypress, 2);
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    chk("defeated_busy", busy, 0);
    repeat (4) @(negedge Clk);
    chk("defeated_x", pacmanX, 631);
    isDefeated = 1'b0;
    frame(630, 231, 2, 1);

    // A second frame_clk rise while busy is dropped
    push(629, 231, 2, 1);
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    repeat (12) @(negedge Clk);
    chk("double_tick_x", pacmanX, 629);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
